// File: rtl/mlp_layer_sequencer.sv
// Control sequencer for the shared-MAC MLP inference engine: walks all three layers,
// drives ROM/activation addresses and datapath strobes, and tracks the layer-3 argmax.
module mlp_layer_sequencer #(
   parameter int unsigned N_IN   = 784,
   parameter int unsigned N_H1   = 200,
   parameter int unsigned N_H2   = 50,
   parameter int unsigned N_OUT  = 10,
   parameter int unsigned DATA_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_stall,
   input  logic signed [DATA_W-1:0] i_acc_in,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [1:0]               o_layer,
   output logic [7:0]               o_neuron_idx,
   output logic [9:0]               o_input_idx,
   output logic [17:0]              o_w_addr,
   output logic [9:0]               o_act_rd_addr,
   output logic                     o_act_rd_bank,
   output logic                     o_mac_clr,
   output logic                     o_mac_en,
   output logic [7:0]               o_bias_addr,
   output logic                     o_bias_en,
   output logic                     o_wb_en,
   output logic                     o_relu_en,
   output logic [7:0]               o_wb_addr,
   output logic                     o_wb_bank,
   output logic [3:0]               o_class_idx
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MAC  = 3'd1;
   localparam logic [2:0] S_BIAS = 3'd2;
   localparam logic [2:0] S_PIPE = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [9:0] LP_F1_LAST = 10'(N_IN - 1);
   localparam logic [9:0] LP_F2_LAST = 10'(N_H1 - 1);
   localparam logic [9:0] LP_F3_LAST = 10'(N_H2 - 1);
   localparam logic [7:0] LP_N1_LAST = 8'(N_H1 - 1);
   localparam logic [7:0] LP_N2_LAST = 8'(N_H2 - 1);
   localparam logic [7:0] LP_N3_LAST = 8'(N_OUT - 1);

   logic [2:0]               r_state;
   logic [1:0]               r_layer;
   logic [7:0]               r_neuron;
   logic [9:0]               r_input;
   logic                     r_addr_vld;
   logic                     r_bias_dly;
   logic signed [DATA_W-1:0] r_max;
   logic [3:0]               r_max_idx;
   logic [3:0]               r_class;

   logic [2:0]               w_state_nxt;
   logic [1:0]               w_layer_nxt;
   logic [7:0]               w_neuron_nxt;
   logic [9:0]               w_input_nxt;
   logic                     w_addr_vld_nxt;
   logic                     w_bias_dly_nxt;
   logic signed [DATA_W-1:0] w_max_nxt;
   logic [3:0]               w_max_idx_nxt;
   logic [3:0]               w_class_nxt;
   logic [9:0]               w_f_last;
   logic [7:0]               w_n_last;
   logic                     w_take_max;

   always_comb begin
      case (r_layer)
         2'd2:    begin w_f_last = LP_F2_LAST; w_n_last = LP_N2_LAST; end
         2'd3:    begin w_f_last = LP_F3_LAST; w_n_last = LP_N3_LAST; end
         default: begin w_f_last = LP_F1_LAST; w_n_last = LP_N1_LAST; end
      endcase
   end

   // Neuron 0 always loads; later neurons win only on strictly greater, so ties keep the lower index.
   assign w_take_max = (r_neuron == 8'd0) || (i_acc_in > r_max);

   always_comb begin
      w_state_nxt    = r_state;
      w_layer_nxt    = r_layer;
      w_neuron_nxt   = r_neuron;
      w_input_nxt    = r_input;
      w_addr_vld_nxt = r_addr_vld;
      w_bias_dly_nxt = r_bias_dly;
      w_max_nxt      = r_max;
      w_max_idx_nxt  = r_max_idx;
      w_class_nxt    = r_class;
      if (r_state == S_DONE) begin
         w_state_nxt = S_IDLE;
      end else if (!i_stall) begin
         w_addr_vld_nxt = (r_state == S_MAC);
         w_bias_dly_nxt = (r_state == S_BIAS);
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  w_state_nxt  = S_MAC;
                  w_layer_nxt  = 2'd1;
                  w_neuron_nxt = 8'd0;
                  w_input_nxt  = 10'd0;
               end
            end
            S_MAC: begin
               if (r_input == w_f_last) begin
                  w_state_nxt = S_BIAS;
                  w_input_nxt = 10'd0;
               end else begin
                  w_input_nxt = r_input + 10'd1;
               end
            end
            S_BIAS:  w_state_nxt = S_PIPE;
            S_PIPE:  w_state_nxt = S_WB;
            S_WB: begin
               if (r_layer == 2'd3 && w_take_max) begin
                  w_max_nxt     = i_acc_in;
                  w_max_idx_nxt = r_neuron[3:0];
               end
               w_state_nxt = S_MAC;
               if (r_neuron == w_n_last) begin
                  w_neuron_nxt = 8'd0;
                  if (r_layer == 2'd3) begin
                     w_state_nxt = S_DONE;
                     w_layer_nxt = 2'd0;
                     w_class_nxt = w_take_max ? r_neuron[3:0] : r_max_idx;
                  end else begin
                     w_layer_nxt = r_layer + 2'd1;
                  end
               end else begin
                  w_neuron_nxt = r_neuron + 8'd1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_layer    <= 2'd0;
         r_neuron   <= 8'd0;
         r_input    <= 10'd0;
         r_addr_vld <= 1'b0;
         r_bias_dly <= 1'b0;
         r_max      <= '0;
         r_max_idx  <= 4'd0;
         r_class    <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_layer    <= w_layer_nxt;
         r_neuron   <= w_neuron_nxt;
         r_input    <= w_input_nxt;
         r_addr_vld <= w_addr_vld_nxt;
         r_bias_dly <= w_bias_dly_nxt;
         r_max      <= w_max_nxt;
         r_max_idx  <= w_max_idx_nxt;
         r_class    <= w_class_nxt;
      end
   end

   assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
   assign o_done        = (r_state == S_DONE);
   assign o_layer       = r_layer;
   assign o_neuron_idx  = r_neuron;
   assign o_input_idx   = r_input;
   assign o_w_addr      = {r_neuron, r_input};
   assign o_act_rd_addr = r_input;
   assign o_act_rd_bank = (r_layer == 2'd2);
   assign o_wb_bank     = (r_layer == 2'd1);
   assign o_bias_addr   = r_neuron;
   assign o_wb_addr     = r_neuron;
   assign o_class_idx   = r_class;

   // Strobes are masked during stall so the datapath sees no work while frozen.
   assign o_mac_clr = (r_state == S_MAC) && (r_input == 10'd0) && !i_stall;
   assign o_mac_en  = r_addr_vld && !i_stall;
   assign o_bias_en = r_bias_dly && !i_stall;
   assign o_wb_en   = (r_state == S_WB) && (r_layer != 2'd3) && !i_stall;
   assign o_relu_en = o_wb_en;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer on a reduced network (12->5->4->10).
module tb_mlp_layer_sequencer;

   localparam int unsigned N_IN  = 12;
   localparam int unsigned N_H1  = 5;
   localparam int unsigned N_H2  = 4;
   localparam int unsigned N_OUT = 10;
   localparam int RUN_LEN  = N_H1 * (N_IN + 3) + N_H2 * (N_H1 + 3) + N_OUT * (N_H2 + 3);
   localparam int MAC_CNT  = N_H1 * N_IN + N_H2 * N_H1 + N_OUT * N_H2;
   localparam int BIAS_CNT = N_H1 + N_H2 + N_OUT;
   localparam int WB_CNT   = N_H1 + N_H2;

   logic              clk, rst_n, start, stall;
   logic signed [15:0] acc_in;
   logic              busy, done, act_rd_bank, mac_clr, mac_en, bias_en, wb_en, relu_en, wb_bank;
   logic [1:0]        layer;
   logic [7:0]        neuron_idx, bias_addr, wb_addr;
   logic [9:0]        input_idx, act_rd_addr;
   logic [17:0]       w_addr;
   logic [3:0]        class_idx;

   mlp_layer_sequencer #(
      .N_IN  (N_IN),
      .N_H1  (N_H1),
      .N_H2  (N_H2),
      .N_OUT (N_OUT),
      .DATA_W(16)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_stall      (stall),
      .i_acc_in     (acc_in),
      .o_busy       (busy),
      .o_done       (done),
      .o_layer      (layer),
      .o_neuron_idx (neuron_idx),
      .o_input_idx  (input_idx),
      .o_w_addr     (w_addr),
      .o_act_rd_addr(act_rd_addr),
      .o_act_rd_bank(act_rd_bank),
      .o_mac_clr    (mac_clr),
      .o_mac_en     (mac_en),
      .o_bias_addr  (bias_addr),
      .o_bias_en    (bias_en),
      .o_wb_en      (wb_en),
      .o_relu_en    (relu_en),
      .o_wb_addr    (wb_addr),
      .o_wb_bank    (wb_bank),
      .o_class_idx  (class_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int va [0:9] = '{-5, 3, 9, 9, -1, 0, 2, 9, 4, 1};
   int vb [0:9] = '{-8, -2, -2, -3, -4, -5, -6, -7, -9, -10};
   logic tbl_sel;

   always_comb begin
      int k;
      k = int'(neuron_idx);
      acc_in = 16'sd77;
      if (layer == 2'd3 && k < 10) acc_in = tbl_sel ? 16'(vb[k]) : 16'(va[k]);
   end

   logic force_stall, stall_en;
   always @(posedge clk) begin
      #2;
      stall = force_stall || (stall_en && ($urandom_range(3) == 0));
   end

   int checks, errors;
   logic [52:0] exp_val [$];
   logic [52:0] exp_msk [$];
   logic [3:0]  exp_class [$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   function automatic logic [52:0] pk(input logic clr, input logic en, input logic bi,
                                      input logic wb, input logic re, input logic ab,
                                      input logic wk, input logic [1:0] ly,
                                      input logic [17:0] wa, input logic [9:0] ra,
                                      input logic [7:0] ba, input logic [7:0] wba);
      return {clr, en, bi, wb, re, ab, wk, ly, wa, ra, ba, wba};
   endfunction

   // Reference strobe stream for one unstalled inference, one entry per busy cycle.
   task automatic push_run(input int cls);
      logic [52:0] ms;
      int f, nn;
      logic w;
      ms = pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, '0, '0, '0, '0);
      for (int l = 1; l <= 3; l++) begin
         f  = (l == 1) ? N_IN : (l == 2) ? N_H1 : N_H2;
         nn = (l == 1) ? N_H1 : (l == 2) ? N_H2 : N_OUT;
         w  = (l < 3);
         for (int n = 0; n < nn; n++) begin
            for (int i = 0; i < f; i++) begin
               exp_val.push_back(pk(i == 0, i > 0, 1'b0, 1'b0, 1'b0, l == 2, 1'b0, 2'(l),
                                    {8'(n), 10'(i)}, 10'(i), '0, '0));
               exp_msk.push_back(ms | pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                                         '1, '1, '0, '0));
            end
            exp_val.push_back(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(l), '0, '0,
                                 8'(n), '0));
            exp_msk.push_back(ms | pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0,
                                      '1, '0));
            exp_val.push_back(pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(l), '0, '0,
                                 '0, '0));
            exp_msk.push_back(ms);
            exp_val.push_back(pk(1'b0, 1'b0, 1'b0, w, w, 1'b0, l == 1, 2'(l), '0, '0, '0,
                                 8'(n)));
            exp_msk.push_back(ms | (w ? pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                                           '0, '0, '0, '1) : '0));
         end
      end
      exp_class.push_back(4'(cls));
   endtask

   // Monitor: pops the reference stream on every unstalled busy cycle and audits each done.
   int busy_cnt, stall_cnt, mac_n, bias_n, wb_n, done_cnt;
   logic prev_busy;
   logic [52:0] mv, mm, ma;
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0; stall_cnt = 0; mac_n = 0; bias_n = 0; wb_n = 0; prev_busy = 1'b0;
      end else begin
         if (busy) begin
            busy_cnt++;
            mac_n  += int'(mac_en);
            bias_n += int'(bias_en);
            wb_n   += int'(wb_en);
            if (stall) begin
               stall_cnt++;
               chk("stall_strobes_low", {mac_clr, mac_en, bias_en, wb_en}, '0);
            end else if (exp_val.size() == 0) begin
               chk("scoreboard_has_entry", 0, 1);
            end else begin
               mv = exp_val.pop_front();
               mm = exp_msk.pop_front();
               ma = pk(mac_clr, mac_en, bias_en, wb_en, relu_en, act_rd_bank, wb_bank, layer,
                       w_addr, act_rd_addr, bias_addr, wb_addr);
               chk("strobe_stream", ma & mm, mv & mm);
            end
         end
         if (done) begin
            done_cnt++;
            chk("busy_low_during_done", busy, 0);
            chk("done_follows_busy", prev_busy, 1);
            chk("busy_length", busy_cnt, RUN_LEN + stall_cnt);
            chk("mac_en_count", mac_n, MAC_CNT);
            chk("bias_en_count", bias_n, BIAS_CNT);
            chk("wb_en_count", wb_n, WB_CNT);
            if (exp_class.size() == 0) chk("class_expected", 0, 1);
            else chk("class_idx", class_idx, exp_class.pop_front());
            busy_cnt = 0; stall_cnt = 0; mac_n = 0; bias_n = 0; wb_n = 0;
         end
         prev_busy = busy;
      end
   end

   function automatic logic [127:0] all_out();
      return {busy, done, layer, neuron_idx, input_idx, w_addr, act_rd_addr, act_rd_bank,
              mac_clr, mac_en, bias_addr, bias_en, wb_en, relu_en, wb_addr, wb_bank, class_idx};
   endfunction

   task automatic start_run();
      start = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (busy) break;
      end
      start = 1'b0;
      chk("start_accepted", busy, 1);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_reached", done, 1);
   endtask

   initial begin
      checks = 0; errors = 0; done_cnt = 0;
      rst_n = 1'b0; start = 1'b0; force_stall = 1'b0; stall_en = 1'b0; tbl_sel = 1'b0;
      stall = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", all_out(), '0);
      rst_n = 1'b1;
      @(posedge clk); #1 chk("idle_outputs", all_out(), '0);

      // Run A: start held while stalled in IDLE is not taken until stall drops.
      push_run(2);
      force_stall = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("start_blocked_by_stall", busy, 0);
      force_stall = 1'b0;
      @(posedge clk); #1 chk("start_after_stall", busy, 1);
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done();

      // Run B: start raised in the done cycle is taken only from IDLE.
      tbl_sel = 1'b1;
      push_run(1);
      start = 1'b1;
      @(posedge clk); #1 chk("start_in_done_ignored", busy, 0);
      @(posedge clk); #1 chk("start_after_done", busy, 1);
      start = 1'b0;
      wait_done();

      // Run C: random stall while busy.
      @(posedge clk); #1;
      tbl_sel = 1'b0;
      push_run(2);
      start_run();
      stall_en = 1'b1;
      wait_done();
      stall_en = 1'b0;

      // Run D: asynchronous reset in the middle of layer 2.
      @(posedge clk); #1;
      push_run(0);
      start_run();
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (layer == 2'd2) break;
      end
      chk("reached_layer2", layer, 2);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset_outputs", all_out(), '0);
      exp_val.delete();
      exp_msk.delete();
      exp_class.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Run E: clean run after the abort.
      tbl_sel = 1'b1;
      push_run(1);
      @(posedge clk); #1;
      start_run();
      wait_done();

      repeat (3) @(posedge clk);
      #1;
      chk("done_count", done_cnt, 4);
      chk("stream_drained", exp_val.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
